// File: rtl/playground.sv
// Two-button hex counter: sync + debounce each switch, count releases, drive active-low 7-seg digits.
// Latency release->segments = 2 + DEBOUNCE_LIMIT + 1 + 1 clocks; no backpressure (free-running inputs).
module playground #(
    parameter int DEBOUNCE_LIMIT = 8
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Segment1_A,
    output logic o_Segment1_B,
    output logic o_Segment1_C,
    output logic o_Segment1_D,
    output logic o_Segment1_E,
    output logic o_Segment1_F,
    output logic o_Segment1_G,
    output logic o_Segment2_A,
    output logic o_Segment2_B,
    output logic o_Segment2_C,
    output logic o_Segment2_D,
    output logic o_Segment2_E,
    output logic o_Segment2_F,
    output logic o_Segment2_G
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_LIMIT - 1);

    // Asserts asynchronously, releases two clocks later so every flop leaves reset on the same edge.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst_int = rst_sync_q[1];

    logic [1:0] sw_raw;
    assign sw_raw = {i_Switch_2, i_Switch_1};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [1:0]    sync_q;
        logic          stable_q, stable_d;
        logic          prev_q;
        logic [CW-1:0] db_cnt_q, db_cnt_d;
        logic [3:0]    cnt_q, cnt_d;
        logic [6:0]    seg_q, seg_d;

        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (sync_q[1] != stable_q) begin
                if (db_cnt_q == DB_LAST) stable_d = sync_q[1];
                else                     db_cnt_d = db_cnt_q + CW'(1);
            end

            // Count on the falling edge of the debounced state (button release).
            cnt_d = cnt_q;
            if (prev_q && !stable_q) cnt_d = cnt_q + 4'd1;

            seg_d = 7'b0000001;
            case (cnt_q)
                4'h0: seg_d = 7'b0000001;
                4'h1: seg_d = 7'b1001111;
                4'h2: seg_d = 7'b0010010;
                4'h3: seg_d = 7'b0000110;
                4'h4: seg_d = 7'b1001100;
                4'h5: seg_d = 7'b0100100;
                4'h6: seg_d = 7'b0100000;
                4'h7: seg_d = 7'b0001111;
                4'h8: seg_d = 7'b0000000;
                4'h9: seg_d = 7'b0000100;
                4'hA: seg_d = 7'b0001000;
                4'hB: seg_d = 7'b1100000;
                4'hC: seg_d = 7'b0110001;
                4'hD: seg_d = 7'b1000010;
                4'hE: seg_d = 7'b0110000;
                4'hF: seg_d = 7'b0111000;
                default: seg_d = 7'b0000001;
            endcase
        end

        always_ff @(posedge i_Clk or posedge rst_int) begin
            if (rst_int) begin
                sync_q   <= 2'b00;
                stable_q <= 1'b0;
                prev_q   <= 1'b0;
                db_cnt_q <= '0;
                cnt_q    <= 4'h0;
                seg_q    <= 7'b0000001;
            end else begin
                sync_q   <= {sync_q[0], sw_raw[ch]};
                stable_q <= stable_d;
                prev_q   <= stable_q;
                db_cnt_q <= db_cnt_d;
                cnt_q    <= cnt_d;
                seg_q    <= seg_d;
            end
        end
    end

    assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
            o_Segment1_E, o_Segment1_F, o_Segment1_G} = g_ch[0].seg_q;
    assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
            o_Segment2_E, o_Segment2_F, o_Segment2_G} = g_ch[1].seg_q;

endmodule

// File: tb/tb_playground.sv
// Bench for playground: directed steps plus random press/glitch trains against a press-count model.
module tb_playground;

    localparam int L = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw1 = 1'b0;
    logic sw2 = 1'b0;
    wire  [6:0] seg1;
    wire  [6:0] seg2;

    int total = 0;
    int bad   = 0;
    int m1    = 0;
    int m2    = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    playground #(.DEBOUNCE_LIMIT(L)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Switch_1  (sw1),
        .i_Switch_2  (sw2),
        .o_Segment1_A(seg1[6]),
        .o_Segment1_B(seg1[5]),
        .o_Segment1_C(seg1[4]),
        .o_Segment1_D(seg1[3]),
        .o_Segment1_E(seg1[2]),
        .o_Segment1_F(seg1[1]),
        .o_Segment1_G(seg1[0]),
        .o_Segment2_A(seg2[6]),
        .o_Segment2_B(seg2[5]),
        .o_Segment2_C(seg2[4]),
        .o_Segment2_D(seg2[3]),
        .o_Segment2_E(seg2[2]),
        .o_Segment2_F(seg2[1]),
        .o_Segment2_G(seg2[0])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input int cnt);
        logic [6:0] exp;
        exp = seg_tab[cnt % 16];
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b (count %0d)", tag, obs, exp, cnt % 16);
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "_d1"}, seg1, m1);
        chk({tag, "_d2"}, seg2, m2);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A high pulse of at least L clocks followed by at least L low clocks is one release.
    task automatic press(input bit c1, input bit c2, input int hi, input int lo);
        if (c1) sw1 = 1'b1;
        if (c2) sw2 = 1'b1;
        ticks(hi);
        sw1 = 1'b0;
        sw2 = 1'b0;
        ticks(lo);
        if (hi >= L && lo >= L) begin
            if (c1) m1++;
            if (c2) m2++;
        end
    endtask

    initial begin
        logic [1:0] mask;
        int hi;
        int lo;

        #1 rst = 1'b1;
        ticks(3);
        chk_both("reset_held");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            ticks(1);
            chk_both("idle");
        end

        press(1'b1, 1'b0, 12, 60);
        chk_both("one_press");

        repeat (3) press(1'b1, 1'b0, 12, 60);
        repeat (2) press(1'b0, 1'b1, 12, 60);
        chk_both("multi");

        press(1'b0, 1'b1, L - 2, 60);
        chk_both("glitch_lm2");
        press(1'b0, 1'b1, L - 1, 60);
        chk_both("glitch_lm1");

        for (int i = 0; i < 20; i++) begin
            sw2 = ~sw2;
            ticks(1);
        end
        press(1'b0, 1'b1, 12, 60);
        chk_both("bounce");

        // Asynchronous reset between edges must clear the digits before the next rising edge.
        ticks(1);
        #2 rst = 1'b1;
        m1 = 0;
        m2 = 0;
        #1 chk_both("async_rst");
        ticks(2);
        rst = 1'b0;
        ticks(5);
        chk_both("post_rst");

        for (int i = 0; i < 16; i++) begin
            press(1'b1, 1'b0, 12, 30);
            if (i == 14) chk("wrap_F", seg1, m1);
        end
        chk("wrap_0", seg1, m1);

        // Simultaneous release on both channels, exact release-to-segment latency.
        sw1 = 1'b1;
        sw2 = 1'b1;
        ticks(20);
        sw1 = 1'b0;
        sw2 = 1'b0;
        ticks(L + 3);
        chk_both("lat_before");
        ticks(1);
        m1++;
        m2++;
        chk_both("lat_at");
        ticks(30);

        sw2 = 1'b1;
        ticks(200);
        chk_both("hold");

        // Reset while held: pending event discarded, later release still counts.
        rst = 1'b1;
        m1 = 0;
        m2 = 0;
        ticks(2);
        rst = 1'b0;
        ticks(30);
        chk_both("rst_midpress");
        sw2 = 1'b0;
        ticks(30);
        m2++;
        chk_both("release_after_rst");

        for (int i = 0; i < 40; i++) begin
            mask = 2'($urandom_range(1, 3));
            hi   = int'($urandom_range(1, 2 * L));
            lo   = int'($urandom_range(L + 5, L + 20));
            press(mask[0], mask[1], hi, lo);
            chk_both("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
